// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the async FIFO write-side arbiter.
// State encodings plus a width helper that never returns zero.
package async_fifo_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    LOCK = ST_LOCK
  } state_e;

  // ceil(log2(n)), but at least 1 so a 1-value range still gets a bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << r) < n) r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit of req at or above start,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = |req;
    // highest offset first so the nearest candidate wins last
    for (int k = N - 1; k >= 0; k--) begin
      if (req[IW'((int'(start) + k) % N)]) begin
        idx = IW'((int'(start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the async FIFO write port; a grant lasts until
// packet end or the MAX_BURST fairness bound, with one idle bubble.
module fifo_wr_arbiter
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IW = clog2(NUM_REQ);
  localparam int BW = clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [BW-1:0]   burst_q, burst_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            own_valid;
  logic            own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic            lock;
  logic            xfer;
  logic            burst_done;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .start (rr_ptr_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign lock       = (state_q == LOCK);
  assign xfer       = lock & own_valid & ~wfull;
  assign burst_done = (MAX_BURST != 0) && (burst_q == BURST_END);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = lock & ~wfull & (grant_q == IW'(i));
    end
  end

  assign winc     = xfer;
  assign wdata    = lock ? own_data : '0;
  assign grant_id = grant_q;
  assign busy     = lock;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    burst_d  = burst_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d  = pick_idx;
          rr_ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
          burst_d  = '0;
          state_d  = LOCK;
        end
      end
      LOCK: begin
        if (xfer) begin
          burst_d = burst_q + 1'b1;
          if (own_last || burst_done) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester model plus a capture
// of every FIFO write, checked against hand-derived sequences.
module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        wrst;
  logic        wfull;
  logic        sel0;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  stall;
  logic [3:0]  all_last;
  logic [7:0]  sent [4];
  logic [7:0]  target [4];

  logic [3:0]  rdy8, rdy0, rdy;
  logic        win8, win0, win;
  logic [7:0]  wd8, wd0, wd;
  logic [1:0]  gid8, gid0, gid;
  logic        bsy8, bsy0, bsy;
  logic [15:0] obs;

  logic [7:0]  wq [$];
  int          n_cmp;
  int          n_err;

  fifo_wr_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .MAX_BURST  (8)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (rdy8),
    .wfull     (wfull),
    .winc      (win8),
    .wdata     (wd8),
    .grant_id  (gid8),
    .busy      (bsy8)
  );

  fifo_wr_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .MAX_BURST  (0)
  ) dut0 (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (rdy0),
    .wfull     (wfull),
    .winc      (win0),
    .wdata     (wd0),
    .grant_id  (gid0),
    .busy      (bsy0)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always_comb begin
    rdy = sel0 ? rdy0 : rdy8;
    win = sel0 ? win0 : win8;
    wd  = sel0 ? wd0  : wd8;
    gid = sel0 ? gid0 : gid8;
    bsy = sel0 ? bsy0 : bsy8;
    obs = {bsy, win, rdy, gid, wd};
  end

  // requester i sends word k as {i, k}; each target batch is one packet
  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (sent[i] != target[i]) & ~stall[i];
      req_last[i]  = all_last[i] | (sent[i] + 8'd1 == target[i]);
      req_data[i*8 +: 8] = {2'(i), sent[i][5:0]};
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      for (int i = 0; i < 4; i++) sent[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] & rdy[i]) sent[i] <= sent[i] + 8'd1;
      end
    end
  end

  always @(posedge wclk) begin
    if (!wrst && win) wq.push_back(wd);
  end

  task automatic do_reset(input logic s);
    @(negedge wclk);
    wrst  = 1'b1;
    sel0  = s;
    wfull = 1'b0;
    stall = '0;
    all_last = '0;
    for (int i = 0; i < 4; i++) target[i] = '0;
    wq.delete();
    @(negedge wclk);
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_err++;
      $display("FAIL rst_state: got %h exp %h", obs, 16'h0);
    end
    target[2] = 8'd3;
    wrst = 1'b0;
    @(negedge wclk);
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 4'b0100, 2'd2, 8'h80}) begin
      n_err++;
      $display("FAIL lock_r2: got %h exp %h", obs,
               {1'b1, 1'b1, 4'b0100, 2'd2, 8'h80});
    end
    wrst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_err++;
      $display("FAIL rst_mid: got %h exp %h", obs, 16'h0);
    end
    for (int i = 0; i < 4; i++) target[i] = 8'd1;
    @(negedge wclk);
    wrst = 1'b0;
    @(negedge wclk);
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 4'b0001, 2'd0, 8'h00}) begin
      n_err++;
      $display("FAIL first_grant: got %h exp %h", obs,
               {1'b1, 1'b1, 4'b0001, 2'd0, 8'h00});
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] e;
    logic [1:0]  g;
    logic [7:0]  d;
    logic [7:0]  exp_q [$];
    do_reset(1'b0);
    all_last = 4'hF;
    for (int i = 0; i < 4; i++) target[i] = 8'd2;
    wrst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge wclk);
      if (k % 2 == 1) begin
        g = 2'((k - 1) / 2);
        d = (k == 9) ? 8'h01 : {g, 6'd0};
        e = {1'b1, 1'b1, 4'b0001 << g, g, d};
      end else begin
        g = 2'((k - 2) / 2);
        e = {1'b0, 1'b0, 4'b0000, g, 8'h00};
      end
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL rr_cyc%0d: got %h exp %h", k, obs, e);
      end
    end
    exp_q = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h01};
    n_cmp++;
    if (wq.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rr_count: got %0d exp %0d", wq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= wq.size() || wq[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rr_word%0d: got %h exp %h", i,
                 (i < wq.size()) ? wq[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_packet_hold();
    logic [15:0] e;
    logic [7:0]  exp_q [$];
    do_reset(1'b1);
    target[0] = 8'd5;
    target[1] = 8'd1;
    wrst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge wclk);
      if (k <= 5) e = {1'b1, 1'b1, 4'b0001, 2'd0, 8'(k - 1)};
      else if (k == 6) e = 16'h0;
      else e = {1'b1, 1'b1, 4'b0010, 2'd1, 8'h40};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL hold_cyc%0d: got %h exp %h", k, obs, e);
      end
    end
    @(negedge wclk);
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h40};
    n_cmp++;
    if (wq.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL hold_count: got %0d exp %0d", wq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= wq.size() || wq[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL hold_word%0d: got %h exp %h", i,
                 (i < wq.size()) ? wq[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_q [$];
    do_reset(1'b0);
    target[2] = 8'd12;
    target[3] = 8'd1;
    wrst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge wclk);
      if (k == 9) begin
        n_cmp++;
        if ({bsy, gid} !== 3'b010) begin
          n_err++;
          $display("FAIL fair_release: got %b exp %b", {bsy, gid}, 3'b010);
        end
      end
      if (k == 10) begin
        n_cmp++;
        if ({bsy, gid} !== 3'b111) begin
          n_err++;
          $display("FAIL fair_r3: got %b exp %b", {bsy, gid}, 3'b111);
        end
      end
      if (k == 12) begin
        n_cmp++;
        if ({bsy, gid} !== 3'b110) begin
          n_err++;
          $display("FAIL fair_resume: got %b exp %b", {bsy, gid}, 3'b110);
        end
      end
    end
    exp_q = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86,
              8'h87, 8'hC0, 8'h88, 8'h89, 8'h8A, 8'h8B};
    n_cmp++;
    if (wq.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL fair_count: got %0d exp %0d", wq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= wq.size() || wq[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL fair_word%0d: got %h exp %h", i,
                 (i < wq.size()) ? wq[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_full();
    logic [15:0] e;
    logic [7:0]  exp_q [$];
    do_reset(1'b0);
    target[1] = 8'd6;
    wrst = 1'b0;
    e = {1'b1, 1'b0, 4'b0000, 2'd1, 8'h42};
    for (int k = 1; k <= 10; k++) begin
      @(negedge wclk);
      if (k == 3) wfull = 1'b1;
      if (k == 6) wfull = 1'b0;
      #1;
      if (k >= 3 && k <= 5) begin
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL full_cyc%0d: got %h exp %h", k, obs, e);
        end
      end
    end
    @(negedge wclk);
    exp_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    n_cmp++;
    if (wq.size() != exp_q.size() || bsy !== 1'b0) begin
      n_err++;
      $display("FAIL full_count: got %0d/%b exp %0d/0", wq.size(), bsy,
               exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= wq.size() || wq[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL full_word%0d: got %h exp %h", i,
                 (i < wq.size()) ? wq[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] e;
    logic [7:0]  exp_q [$];
    do_reset(1'b0);
    target[1] = 8'd4;
    wrst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge wclk);
      if (k == 2) begin
        stall[1]  = 1'b1;
        target[0] = 8'd2;
      end
      if (k == 6) stall[1] = 1'b0;
      #1;
      if (k >= 2 && k <= 5) begin
        e = {1'b1, 1'b0, 4'b0010, 2'd1, 8'h41};
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL stall_cyc%0d: got %h exp %h", k, obs, e);
        end
      end
      if (k == 10) begin
        e = {1'b1, 1'b1, 4'b0001, 2'd0, 8'h00};
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL stall_next: got %h exp %h", obs, e);
        end
      end
    end
    @(negedge wclk);
    exp_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h00, 8'h01};
    n_cmp++;
    if (wq.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL stall_count: got %0d exp %0d", wq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= wq.size() || wq[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL stall_word%0d: got %h exp %h", i,
                 (i < wq.size()) ? wq[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    wrst     = 1'b1;
    wfull    = 1'b0;
    sel0     = 1'b0;
    stall    = '0;
    all_last = '0;
    for (int i = 0; i < 4; i++) target[i] = '0;
    test_reset();
    test_round_robin();
    test_packet_hold();
    test_fairness();
    test_full();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
